xnor_popcount_fc_array: RTL
===========================

Name: xnor_popcount_fc_array

Overview:
- Parametrised multi-neuron binary fully-connected stage.
- Computes N_OUT XNOR-popcount dot products in parallel over an N_IN-bit binarised activation vector.
- Consumes BPC activation bits per accepted beat.
- Emits signed pre-activations (2·pop − N_IN) plus sign bits for the next binarised layer.
- Sits after the last conv/pool binarisation stage and feeds the classifier argmax or the next FC stage.

Parameters:
- N_IN, 54, activation vector length (fan-in per neuron), ≥1.
- BPC, 2, activation bits consumed per beat, 1..N_IN.
- N_OUT, 4, neurons computed in parallel.
- OL, 7, signed output width; must satisfy OL ≥ clog2(N_IN+1)+1.

Ports:
- iCLK  input  1  clock, rising edge.
- iRST  input  1  asynchronous, active-high reset.
- iSTART  input  1  frame start pulse; clears accumulators and begins a frame.
- iVALID  input  1  beat valid; iDATA/iWEIGHT are sampled when high in ACC.
- iDATA  input  BPC  activation bits; bit k of beat b is vector bit b·BPC+k.
- iWEIGHT  input  N_OUT·BPC  weights; slice [n·BPC +: BPC] belongs to neuron n.
- oDATA  output  N_OUT·OL  signed results; slice [n·OL +: OL] belongs to neuron n.
- oSIGN  output  N_OUT  binarised result per neuron: 1 when 2·pop ≥ N_IN.
- oVALID  output  1  one-cycle pulse when oDATA/oSIGN are updated.
- oBUSY  output  1  high while state ≠ IDLE.

Behaviour:
- Derived constants:
  - NB = ceil(N_IN/BPC) beats per frame.
  - PCW = clog2(N_IN+1) popcount width.
  - Beat counter width clog2(NB+1).
- Reset (async): state=IDLE, all accumulators=0, beat counter=0, oDATA=0, oSIGN=0, oVALID=0.
- FSM states IDLE, ACC, DONE:
  - IDLE: iSTART → ACC, clear accumulators and beat counter. iVALID ignored.
  - ACC: iVALID=1 accepts a beat:
    - For each neuron n: acc[n] += popcount(~(iDATA ^ w_n) & mask).
    - Beat counter increments.
    - When the accepted beat is beat NB−1, go to DONE.
    - iVALID=0: hold everything (gaps allowed, no timeout).
  - DONE (one cycle):
    - oDATA[n] = 2·acc[n] − N_IN, as OL-bit two's complement.
    - oSIGN[n] = (2·acc[n] ≥ N_IN).
    - oVALID=1 for exactly that next cycle, then → IDLE.
- Mask:
  - All ones except on the final beat when N_IN mod BPC ≠ 0.
  - On that final beat only the low (N_IN mod BPC) bits count; upper bits are don't-care.
- Latency:
  - Edge E0 accepts the last beat.
  - Edge E1 loads outputs and raises oVALID.
  - oVALID is high in the cycle following E1, i.e. 2 cycles after the last beat is presented.
- oDATA/oSIGN hold their last values until the next DONE load; they are not cleared by iSTART.
- iSTART priority, any state:
  - Clears accumulators and beat counter, forces ACC.
  - In DONE: the pending result is dropped; no oVALID, outputs unchanged.
  - A beat presented with iVALID in the same cycle as iSTART is discarded.
- Per-beat accumulation is computed at PCW width with no wrap; the maximum is N_IN.
- The output subtraction is done at OL+1 bits and truncated to OL; the range −N_IN..+N_IN is always representable.
- Per-neuron logic is identical, generated N_OUT times; there is no inter-neuron dependency.
- oBUSY = (state ≠ IDLE), combinational from the state register.

Test Plan:
- Defaults; iSTART, then 27 beats with iDATA=2'b11 and all weights 1 → oVALID pulse 2 cycles after beat 27; every oDATA slice = 7'h36 (+54); oSIGN=4'b1111.
- Defaults; data all 1, weights all 0 → every slice = 7'h4A (−54); oSIGN=0. Neuron 2 weights = data on exactly 27 bits → slice 2 = 0, oSIGN[2]=1.
- N_IN=5, BPC=2, N_OUT=1:
  - 3 beats of data=11, weight=11, but the final beat has weight bit1=0 → result +5 (masked bit ignored).
  - With bit0 of the final beat mismatched instead → +3.
- Defaults; iVALID toggled 1/0 every cycle across the frame → results identical to the gap-free run; oVALID fires only after the 27th accepted beat; oBUSY high from iSTART until the DONE cycle.
- Defaults; iSTART re-asserted after 10 beats, followed by 27 all-match beats → single oVALID, result +54; the first 10 beats have no effect. iSTART during DONE → no oVALID, oDATA keeps its previous value.
- iRST asserted mid-frame (beat 15) → all outputs 0 immediately and state IDLE. A subsequent iVALID without iSTART is ignored, with no oVALID.

Source files
------------

// File: rtl/xnor_popcount_fc_array.sv
// ---------------------------------------------------------------------------
// xnor_popcount_fc_array
//
// Binary fully-connected stage. N_OUT neurons compute XNOR-popcount dot
// products in parallel over an N_IN-bit binarised activation vector. The
// vector arrives BPC bits per accepted beat. Each neuron produces a signed
// pre-activation (2*pop - N_IN) and a sign bit for the next binarised layer.
//
// Ports:
//   iCLK     in   1            clock, rising edge
//   iRST     in   1            asynchronous reset, active high
//   iSTART   in   1            frame start; clears accumulators, enters ACC
//   iVALID   in   1            beat valid, sampled in ACC only
//   iDATA    in   BPC          activation bits; bit k of beat b = vector bit b*BPC+k
//   iWEIGHT  in   N_OUT*BPC    weights; [n*BPC +: BPC] belongs to neuron n
//   oDATA    out  N_OUT*OL     signed results; [n*OL +: OL] belongs to neuron n
//   oSIGN    out  N_OUT        1 when 2*pop >= N_IN
//   oVALID   out  1            one-cycle pulse when oDATA/oSIGN are updated
//   oBUSY    out  1            high while the FSM is not IDLE
// ---------------------------------------------------------------------------
module xnor_popcount_fc_array #(
    parameter int N_IN  = 54,
    parameter int BPC   = 2,
    parameter int N_OUT = 4,
    parameter int OL    = 7
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic                   iSTART,
    input  logic                   iVALID,
    input  logic [BPC-1:0]         iDATA,
    input  logic [N_OUT*BPC-1:0]   iWEIGHT,
    output logic [N_OUT*OL-1:0]    oDATA,
    output logic [N_OUT-1:0]       oSIGN,
    output logic                   oVALID,
    output logic                   oBUSY
);

    localparam int NB  = (N_IN + BPC - 1) / BPC;  // beats per frame
    localparam int PCW = $clog2(N_IN + 1);        // popcount width
    localparam int BCW = $clog2(NB + 1);          // beat counter width
    localparam int REM = N_IN % BPC;              // valid bits on a partial final beat

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [N_OUT-1:0][PCW-1:0]    acc_q, acc_d;
    logic [BCW-1:0]               beat_q, beat_d;
    logic [N_OUT*OL-1:0]          odata_q, odata_d;
    logic [N_OUT-1:0]             osign_q, osign_d;
    logic                         ovalid_q, ovalid_d;

    logic                         last_beat_s;
    logic [BPC-1:0]               mask_s;
    logic [N_OUT-1:0][PCW-1:0]    pop_s;
    logic [N_OUT*OL-1:0]          res_s;
    logic [N_OUT-1:0]             sgn_s;

    assign last_beat_s = (beat_q == BCW'(NB - 1));

    // Beat mask: on a partial final beat only the low REM bits contribute.
    always_comb begin
        mask_s = '1;
        for (int k = 0; k < BPC; k++) begin
            if (last_beat_s && (REM != 0) && (k >= REM)) begin
                mask_s[k] = 1'b0;
            end else begin
                mask_s[k] = 1'b1;
            end
        end
    end

    // Identical per-neuron datapath: beat popcount plus final result shaping.
    for (genvar g = 0; g < N_OUT; g++) begin : g_neuron
        // XNOR-popcount of the current beat for neuron g (max BPC, fits PCW).
        always_comb begin
            pop_s[g] = '0;
            for (int k = 0; k < BPC; k++) begin
                pop_s[g] = pop_s[g] + PCW'(~(iDATA[k] ^ iWEIGHT[g*BPC + k]) & mask_s[k]);
            end
        end

        // 2*acc - N_IN; the top bit of a wider subtraction is always dropped,
        // and -N_IN..+N_IN fits OL bits, so computing at OL bits is exact.
        assign res_s[g*OL +: OL] = OL'({acc_q[g], 1'b0}) - OL'(N_IN);
        assign sgn_s[g]          = ({acc_q[g], 1'b0} >= (PCW+1)'(N_IN));
    end

    // Next-state, accumulator and output-load logic; iSTART overrides all states.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        beat_d   = beat_q;
        odata_d  = odata_q;
        osign_d  = osign_q;
        ovalid_d = 1'b0;
        if (iSTART) begin
            state_d = ST_ACC;
            acc_d   = '0;
            beat_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ACC: begin
                    if (iVALID) begin
                        for (int n = 0; n < N_OUT; n++) begin
                            acc_d[n] = acc_q[n] + pop_s[n];
                        end
                        beat_d = beat_q + BCW'(1);
                        if (last_beat_s) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ACC;
                        end
                    end else begin
                        state_d = ST_ACC;
                    end
                end
                ST_DONE: begin
                    odata_d  = res_s;
                    osign_d  = sgn_s;
                    ovalid_d = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, accumulator and output registers.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            beat_q   <= '0;
            odata_q  <= '0;
            osign_q  <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            beat_q   <= beat_d;
            odata_q  <= odata_d;
            osign_q  <= osign_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign oDATA  = odata_q;
    assign oSIGN  = osign_q;
    assign oVALID = ovalid_q;
    assign oBUSY  = (state_q != ST_IDLE);

endmodule
